data_op_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the three-digit dekatron data counter and drives its Step, Reverse, Set and In inputs. It accepts one data-cell command per handshake: increment, decrement, load, or no-op, with a BCD repeat count. It converts the command into correctly spaced Step pulses with a settle gap and reports completion plus a zero flag sampled from the counter's BCD output.

---
 rtl/data_op_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_data_op_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_op_sequencer.sv
// Command sequencer in front of the dekatron data counter: turns INC/DEC/LOAD/NOP
// commands with a BCD repeat count into spaced Step pulses and reports completion.
module data_op_sequencer #(
  parameter int STEP_HIGH = 2,
  parameter int SETTLE    = 3
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Request,
  output logic        Ready,
  input  logic [1:0]  Op,
  input  logic [11:0] Count,
  input  logic [11:0] LoadValue,
  input  logic [11:0] DataOut,
  output logic        Step,
  output logic        Reverse,
  output logic        Set,
  output logic [11:0] In,
  output logic        Busy,
  output logic        Done,
  output logic        IsZero
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_STEP_HI = 3'd2;
  localparam logic [2:0] S_STEP_LO = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  localparam logic [7:0] HI_LAST = 8'(STEP_HIGH - 1);
  localparam logic [7:0] LO_LAST = 8'(SETTLE - 1);

  // Saturate each BCD digit at 9 so a malformed count still means "as many as possible".
  function automatic logic [11:0] bcd_clamp(input logic [11:0] v);
    logic [3:0] d2, d1, d0;
    d2 = (v[11:8] > 4'd9) ? 4'd9 : v[11:8];
    d1 = (v[7:4]  > 4'd9) ? 4'd9 : v[7:4];
    d0 = (v[3:0]  > 4'd9) ? 4'd9 : v[3:0];
    return {d2, d1, d0};
  endfunction

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] d2, d1, d0;
    d2 = v[11:8];
    d1 = v[7:4];
    d0 = v[3:0];
    if (d0 != 4'd0) begin
      d0 = d0 - 4'd1;
    end else begin
      d0 = 4'd9;
      if (d1 != 4'd0) begin
        d1 = d1 - 4'd1;
      end else begin
        d1 = 4'd9;
        if (d2 != 4'd0) begin
          d2 = d2 - 4'd1;
        end else begin
          d2 = 4'd9;
        end
      end
    end
    return {d2, d1, d0};
  endfunction

  logic [2:0]  state_q,  state_d;
  logic [7:0]  cnt_q,    cnt_d;
  logic [11:0] rem_q,    rem_d;
  logic [1:0]  op_q,     op_d;
  logic        rev_q,    rev_d;
  logic [11:0] in_q,     in_d;
  logic        step_q,   step_d;
  logic        set_q,    set_d;
  logic        done_q,   done_d;
  logic        ready_q,  ready_d;
  logic        busy_q,   busy_d;
  logic        iszero_q, iszero_d;
  logic [11:0] rem_dec_s;
  logic        step_op_s;

  assign rem_dec_s = bcd_dec(rem_q);
  assign step_op_s = (op_q == OP_INC) || (op_q == OP_DEC);

  // Next-state logic; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    op_d     = op_q;
    rev_d    = rev_q;
    in_d     = in_q;
    case (state_q)
      S_IDLE: begin
        if (Request) begin
          op_d    = Op;
          rem_d   = bcd_clamp(Count);
          rev_d   = (Op == OP_DEC);
          if (Op == OP_LOAD) begin
            in_d = LoadValue;
          end else begin
            in_d = in_q;
          end
          cnt_d   = 8'd0;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        cnt_d = 8'd0;
        if ((op_q == OP_LOAD) || (step_op_s && (rem_q != 12'h000))) begin
          state_d = S_STEP_HI;
        end else begin
          state_d = S_DONE;
        end
      end
      S_STEP_HI: begin
        if (cnt_q == HI_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_STEP_LO;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_STEP_LO: begin
        if (cnt_q == LO_LAST) begin
          cnt_d = 8'd0;
          if (op_q == OP_LOAD) begin
            state_d = S_DONE;
          end else begin
            rem_d = rem_dec_s;
            if (rem_dec_s != 12'h000) begin
              state_d = S_STEP_HI;
            end else begin
              state_d = S_DONE;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    step_d  = (state_d == S_STEP_HI);
    set_d   = step_d && (op_d == OP_LOAD);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
    busy_d  = ~ready_d;
    if (done_d) begin
      iszero_d = (DataOut == 12'h000);
    end else begin
      iszero_d = iszero_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      rem_q    <= 12'h000;
      op_q     <= 2'b11;
      rev_q    <= 1'b0;
      in_q     <= 12'h000;
      step_q   <= 1'b0;
      set_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      iszero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      rev_q    <= rev_d;
      in_q     <= in_d;
      step_q   <= step_d;
      set_q    <= set_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      iszero_q <= iszero_d;
    end
  end

  assign Ready   = ready_q;
  assign Busy    = busy_q;
  assign Step    = step_q;
  assign Set     = set_q;
  assign Reverse = rev_q;
  assign In      = in_q;
  assign Done    = done_q;
  assign IsZero  = iszero_q;

endmodule

// File: tb/tb_data_op_sequencer.sv
// Self-checking bench for data_op_sequencer: directed table, random commands,
// busy-request and mid-operation reset sequences, with a simple counter model on DataOut.
module tb_data_op_sequencer;

  localparam int SH = 2;
  localparam int ST = 3;
  localparam int P  = SH + ST;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Request = 1'b0;
  logic        Ready;
  logic [1:0]  Op = 2'b11;
  logic [11:0] Count = 12'h000;
  logic [11:0] LoadValue = 12'h000;
  logic [11:0] DataOut;
  logic        Step, Reverse, Set, Busy, Done, IsZero;
  logic [11:0] In;

  int test_cnt = 0;
  int fail_cnt = 0;

  data_op_sequencer #(.STEP_HIGH(SH), .SETTLE(ST)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Request(Request), .Ready(Ready), .Op(Op),
    .Count(Count), .LoadValue(LoadValue), .DataOut(DataOut), .Step(Step),
    .Reverse(Reverse), .Set(Set), .In(In), .Busy(Busy), .Done(Done), .IsZero(IsZero)
  );

  always #5 Clk = ~Clk;

  function automatic int bcd2int(input logic [11:0] v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_n(input logic [11:0] v);
    int d2, d1, d0;
    d2 = (int'(v[11:8]) > 9) ? 9 : int'(v[11:8]);
    d1 = (int'(v[7:4])  > 9) ? 9 : int'(v[7:4]);
    d0 = (int'(v[3:0])  > 9) ? 9 : int'(v[3:0]);
    return d2 * 100 + d1 * 10 + d0;
  endfunction

  // Dekatron counter model: acts on each rising Step edge.
  int   cnt_v = 0;
  logic step_prev = 1'b0;
  assign DataOut = int2bcd(cnt_v);
  always @(posedge Clk) begin
    if (Step && !step_prev) begin
      if (Set) cnt_v <= bcd2int(In);
      else if (Reverse) cnt_v <= (cnt_v + 999) % 1000;
      else cnt_v <= (cnt_v + 1) % 1000;
    end
    step_prev <= Step;
  end

  // Reference state kept by the bench
  int          ref_v = 0;
  logic [11:0] ref_in = 12'h000;
  logic        ref_zero = 1'b0;

  task automatic chk(input string nm, input int c, input logic [31:0] got, input logic [31:0] exp);
    test_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, c, got, exp);
    end
  endtask

  function automatic logic [18:0] outs();
    return {Ready, Busy, Step, Set, Done, Reverse, IsZero, In};
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [11:0] cnt, input logic [11:0] lv,
                         input bit spam, output int done_c, output int pulses,
                         output logic zero_seen, output logic rev_seen);
    int n, exp_done, new_v;
    logic [11:0] new_in;
    logic new_zero, e_step, e_done, e_ready, e_zero, prev_step;
    bit is_load, is_stp;
    n       = clamp_n(cnt);
    is_load = (op == 2'b10);
    is_stp  = (op == 2'b00) || (op == 2'b01);
    if (is_load) exp_done = 2 + P;
    else if (is_stp && n != 0) exp_done = 2 + n * P;
    else exp_done = 2;
    if (is_load) new_v = bcd2int(lv);
    else if (op == 2'b00) new_v = (ref_v + n) % 1000;
    else if (op == 2'b01) new_v = (ref_v + 1000 - (n % 1000)) % 1000;
    else new_v = ref_v;
    new_zero = (new_v == 0);
    new_in   = is_load ? lv : ref_in;
    chk("ready_before_accept", 0, 32'(Ready), 32'd1);
    Request = 1'b1; Op = op; Count = cnt; LoadValue = lv;
    @(posedge Clk);
    #1;
    if (spam) begin
      Op = 2'b01; Count = 12'h999; LoadValue = 12'h555;
    end else begin
      Request = 1'b0;
    end
    done_c = 0; pulses = 0; zero_seen = 1'b0; rev_seen = 1'b0; prev_step = 1'b0;
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge Clk);
      e_step  = (c >= 2) && (c < exp_done) && (((c - 2) % P) < SH);
      e_done  = (c == exp_done);
      e_ready = (c == exp_done + 1);
      e_zero  = (c >= exp_done) ? new_zero : ref_zero;
      chk("cycle_outputs", c, 32'(outs()),
          32'({e_ready, !e_ready, e_step, e_step && is_load, e_done, op == 2'b01, e_zero, new_in}));
      if (Step && !prev_step) pulses++;
      prev_step = Step;
      if (Done && done_c == 0) begin
        done_c = c;
        zero_seen = IsZero;
      end
      if (c == 1) rev_seen = Reverse;
      if (c >= exp_done) Request = 1'b0;
    end
    ref_v = new_v; ref_in = new_in; ref_zero = new_zero;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] cnt;
    logic [11:0] lv;
    bit          spam;
    int          exp_done;
    int          exp_pulses;
    logic        exp_rev;
    logic        exp_zero;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int dc, pc;
    logic zs, rs;
    logic [1:0]  rop;
    logic [11:0] rcnt, rlv;
    tbl[0] = '{2'b10, 12'h000, 12'h000, 1'b0, 7,    1,   1'b0, 1'b1};
    tbl[1] = '{2'b00, 12'h003, 12'h000, 1'b1, 17,   3,   1'b0, 1'b0};
    tbl[2] = '{2'b10, 12'h000, 12'h000, 1'b0, 7,    1,   1'b0, 1'b1};
    tbl[3] = '{2'b01, 12'h010, 12'h000, 1'b0, 52,   10,  1'b1, 1'b0};
    tbl[4] = '{2'b10, 12'h000, 12'h128, 1'b0, 7,    1,   1'b0, 1'b0};
    tbl[5] = '{2'b10, 12'h000, 12'h000, 1'b0, 7,    1,   1'b0, 1'b1};
    tbl[6] = '{2'b00, 12'h000, 12'h000, 1'b0, 2,    0,   1'b0, 1'b1};
    tbl[7] = '{2'b11, 12'h123, 12'h000, 1'b0, 2,    0,   1'b0, 1'b1};
    tbl[8] = '{2'b00, 12'hFFF, 12'h000, 1'b0, 4997, 999, 1'b0, 1'b0};

    repeat (3) @(negedge Clk);
    chk("reset_outputs", 0, 32'(outs()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000}));
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("idle_outputs", 0, 32'(outs()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000}));

    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].lv, tbl[i].spam, dc, pc, zs, rs);
      chk("tbl_done_cycle", i, 32'(dc), 32'(tbl[i].exp_done));
      chk("tbl_pulses", i, 32'(pc), 32'(tbl[i].exp_pulses));
      chk("tbl_reverse_setup", i, 32'(rs), 32'(tbl[i].exp_rev));
      chk("tbl_iszero", i, 32'(zs), 32'(tbl[i].exp_zero));
    end

    // Abort an INC 005 during its second Step-high phase.
    Request = 1'b1; Op = 2'b00; Count = 12'h005;
    @(posedge Clk);
    #1 Request = 1'b0;
    for (int c = 1; c <= 7; c++) @(negedge Clk);
    chk("abort_step_before", 7, 32'(Step), 32'd1);
    Rst_n = 1'b0;
    #1;
    chk("abort_async_reset", 7, 32'(outs()), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000}));
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk("abort_no_done", c, 32'({Done, Ready}), 32'({1'b0, 1'b1}));
    end
    Rst_n = 1'b1;
    ref_v = (ref_v + 1) % 1000; ref_in = 12'h000; ref_zero = 1'b0;
    @(negedge Clk);
    run_cmd(2'b00, 12'h002, 12'h000, 1'b0, dc, pc, zs, rs);
    chk("post_abort_done", 0, 32'(dc), 32'd12);
    chk("post_abort_pulses", 0, 32'(pc), 32'd2);

    // Random commands against the reference model.
    for (int i = 0; i < 25; i++) begin
      rop  = 2'($urandom_range(0, 3));
      rcnt = {4'($urandom_range(0, 1) * $urandom_range(0, 1)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      rlv  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      run_cmd(rop, rcnt, rlv, bit'($urandom_range(0, 1)), dc, pc, zs, rs);
      chk("rand_pulses", i, 32'(pc),
          32'((rop == 2'b10) ? 1 : ((rop == 2'b11) ? 0 : clamp_n(rcnt))));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
